pc_sequencer: RTL and testbench

Program-counter sequencer for the 8-bit-address MIPS core. It owns the PC register and applies redirects from the jump control logic (jmp_req/jmp_loc). It also handles interrupt entry and return: it saves the return address and execution flags on a small hardware return stack, vectors to 0xF0, and restores both on the RETI opcode. It sits between the jump control block and instruction fetch.

---
 rtl/pc_sequencer_pkg.sv | 15 +
 rtl/pc_sequencer_if.sv | 25 ++
 rtl/pc_sequencer_ret_stack.sv | 30 +++
 rtl/pc_sequencer.sv | 79 +++++++
 tb/tb_pc_sequencer.sv | 174 +++++++++++++++++
 5 files changed

// File: rtl/pc_sequencer_pkg.sv
// pc_seq_pkg: shared FSM states, opcodes, vector address and return-stack frame type
package pc_seq_pkg;
  typedef enum logic [2:0] {RUN, SAVE, VECTOR, RESTORE, FAULT} state_t;
  localparam logic [4:0] RETI_OP_DEF = 5'b10000;
  localparam logic [4:0] OP_JMP = 5'b11000;
  localparam logic [4:0] OP_JZ = 5'b11110;
  localparam logic [4:0] OP_JNZ = 5'b11111;
  localparam logic [4:0] OP_JC = 5'b11100;
  localparam logic [4:0] OP_JNC = 5'b11101;
  localparam logic [7:0] IRQ_VECTOR_DEF = 8'hF0;
  typedef struct packed {
    logic [7:0] addr;
    logic [3:0] flags;
  } frame_t;
endpackage

// File: rtl/pc_sequencer_if.sv
// pc_seq_if: sequencer bus; master drives stall/jmp/ins_op/flag_ex/irq/irq_en, slave returns pc/irq_ack/flag_restore(_valid)/in_isr/depth/fault
interface pc_seq_if;
  logic stall;
  logic jmp_req;
  logic [7:0] jmp_loc;
  logic [4:0] ins_op;
  logic [3:0] flag_ex;
  logic irq;
  logic irq_en;
  logic [7:0] pc;
  logic irq_ack;
  logic [3:0] flag_restore;
  logic flag_restore_valid;
  logic in_isr;
  logic [3:0] depth;
  logic fault;
  modport master(
    output stall, jmp_req, jmp_loc, ins_op, flag_ex, irq, irq_en,
    input pc, irq_ack, flag_restore, flag_restore_valid, in_isr, depth, fault
  );
  modport slave(
    input stall, jmp_req, jmp_loc, ins_op, flag_ex, irq, irq_en,
    output pc, irq_ack, flag_restore, flag_restore_valid, in_isr, depth, fault
  );
endinterface

// File: rtl/pc_sequencer_ret_stack.sv
// ret_stack: LIFO of {addr,flags} frames; clk/reset, push/pop/din in, top/depth/full/empty out
module ret_stack
  import pc_seq_pkg::*;
#(
  parameter int DEPTH = 4,
  localparam int W = $clog2(DEPTH) + 1
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         push,
  input  logic         pop,
  input  frame_t       din,
  output frame_t       top,
  output logic [W-1:0] depth,
  output logic         full,
  output logic         empty
);
  frame_t mem [DEPTH];
  logic [W-1:0] top_idx;
  assign top_idx = depth - W'(1);
  assign top = mem[top_idx[W-2:0]];
  assign full = depth == W'(DEPTH);
  assign empty = depth == '0;
  always_ff @(posedge clk)
    if (push) mem[depth[W-2:0]] <= din;
  always_ff @(posedge clk)
    if (reset) depth <= '0;
    else if (push) depth <= depth + W'(1);
    else if (pop) depth <= depth - W'(1);
endmodule

// File: rtl/pc_sequencer.sv
// pc_sequencer: PC register with jump redirects and interrupt save/vector/restore; clk, reset, pc_seq_if.slave bus
module pc_sequencer
  import pc_seq_pkg::*;
#(
  parameter int STACK_DEPTH = 4,
  parameter logic [7:0] IRQ_VECTOR = IRQ_VECTOR_DEF,
  parameter logic [4:0] RETI_OP = RETI_OP_DEF
) (
  input logic clk,
  input logic reset,
  pc_seq_if.slave b
);
  localparam int W = $clog2(STACK_DEPTH) + 1;
  state_t state;
  frame_t saved, top;
  logic [W-1:0] sdepth;
  logic full, empty, irq_d, irq_pend, is_reti, accept;
  logic [7:0] next_pc;
  assign is_reti = b.ins_op == RETI_OP;
  assign accept = state == RUN && !b.stall && !is_reti && irq_pend && b.irq_en && !full;
  assign next_pc = b.jmp_req ? b.jmp_loc : b.pc + 8'd1;
  assign b.in_isr = !empty;
  assign b.depth = 4'(sdepth);
  ret_stack #(.DEPTH(STACK_DEPTH)) u_stack (
    .clk(clk),
    .reset(reset),
    .push(state == SAVE),
    .pop(state == RESTORE),
    .din(saved),
    .top(top),
    .depth(sdepth),
    .full(full),
    .empty(empty)
  );
  always_ff @(posedge clk)
    if (reset) begin
      state <= RUN;
      b.pc <= 8'h00;
      irq_d <= 1'b0;
      irq_pend <= 1'b0;
      b.irq_ack <= 1'b0;
      b.flag_restore <= 4'h0;
      b.flag_restore_valid <= 1'b0;
      b.fault <= 1'b0;
    end else begin
      irq_d <= b.irq;
      irq_pend <= (b.irq && !irq_d) || (irq_pend && !accept);
      b.irq_ack <= accept;
      b.flag_restore_valid <= state == RESTORE;
      case (state)
        RUN:
          if (!b.stall) begin
            if (is_reti) begin
              state <= empty ? FAULT : RESTORE;
              b.fault <= empty;
            end else begin
              // the accept edge still advances pc to the return address, so it is held through SAVE
              b.pc <= next_pc;
              if (accept) begin
                saved <= {next_pc, b.flag_ex};
                state <= SAVE;
              end
            end
          end
        SAVE: state <= VECTOR;
        VECTOR: begin
          b.pc <= IRQ_VECTOR;
          state <= RUN;
        end
        RESTORE: begin
          b.pc <= top.addr;
          b.flag_restore <= top.flags;
          state <= RUN;
        end
        FAULT: b.fault <= 1'b1;
        default: state <= RUN;
      endcase
    end
endmodule

// File: tb/tb_pc_sequencer.sv
// tb_pc_sequencer: scoreboard bench for pc_sequencer
module tb_pc_sequencer;
  import pc_seq_pkg::*;
  logic clk = 1'b0;
  logic reset = 1'b1;
  int passed = 0;
  int total = 0;
  logic [7:0] exp_q[$];
  logic ack_q[$];
  logic [11:0] ret_q[$];
  pc_seq_if b();
  pc_sequencer dut(.clk(clk), .reset(reset), .b(b));
  always #5 clk = ~clk;
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic clear_inputs();
    b.stall = 0; b.jmp_req = 0; b.jmp_loc = 0; b.ins_op = 0;
    b.flag_ex = 0; b.irq = 0; b.irq_en = 1;
  endtask
  task automatic restart();
    reset = 1; clear_inputs(); tick(); reset = 0;
  endtask
  task automatic test_reset();
    clear_inputs(); reset = 1; tick(); tick();
    total++; if (b.pc !== 8'h00) $display("FAIL reset_pc got %h want 00", b.pc); else passed++;
    total++; if (b.depth !== 4'd0 || b.in_isr !== 1'b0) $display("FAIL reset_depth got %0d/%b want 0/0", b.depth, b.in_isr); else passed++;
    total++; if ({b.irq_ack, b.flag_restore_valid, b.fault} !== 3'b000) $display("FAIL reset_flags got %b want 000", {b.irq_ack, b.flag_restore_valid, b.fault}); else passed++;
    total++; if (b.flag_restore !== 4'h0) $display("FAIL reset_flag_restore got %h want 0", b.flag_restore); else passed++;
    reset = 0;
  endtask
  task automatic test_freerun();
    logic [7:0] e;
    restart();
    for (int i = 1; i <= 300; i++) begin
      exp_q.push_back(8'(i));
      tick();
      e = exp_q.pop_front();
      total++; if (b.pc !== e) $display("FAIL freerun_pc cycle %0d got %h want %h", i, b.pc, e); else passed++;
      total++; if ({b.irq_ack, b.flag_restore_valid, b.fault, b.in_isr} !== 4'b0) $display("FAIL freerun_quiet cycle %0d got %b want 0000", i, {b.irq_ack, b.flag_restore_valid, b.fault, b.in_isr}); else passed++;
    end
  endtask
  task automatic test_jump();
    logic [7:0] e;
    restart();
    repeat (5) tick();
    total++; if (b.pc !== 8'h05) $display("FAIL jump_start got %h want 05", b.pc); else passed++;
    b.stall = 1; b.jmp_req = 1; b.jmp_loc = 8'h3A; exp_q.push_back(8'h05);
    tick(); e = exp_q.pop_front();
    total++; if (b.pc !== e) $display("FAIL jump_stalled got %h want %h", b.pc, e); else passed++;
    b.stall = 0; exp_q.push_back(8'h3A);
    tick(); e = exp_q.pop_front();
    total++; if (b.pc !== e) $display("FAIL jump_taken got %h want %h", b.pc, e); else passed++;
    b.jmp_req = 0; exp_q.push_back(8'h3B);
    tick(); e = exp_q.pop_front();
    total++; if (b.pc !== e) $display("FAIL jump_after got %h want %h", b.pc, e); else passed++;
  endtask
  task automatic test_irq();
    logic [7:0] e;
    logic a;
    logic [11:0] f;
    restart();
    repeat (15) tick();
    b.irq = 1; b.flag_ex = 4'b0011;
    exp_q.push_back(8'h10); exp_q.push_back(8'h11); exp_q.push_back(8'h11); exp_q.push_back(8'hF0);
    ack_q.push_back(0); ack_q.push_back(1); ack_q.push_back(0); ack_q.push_back(0);
    ret_q.push_back({8'h11, 4'b0011});
    for (int i = 0; i < 4; i++) begin
      tick(); b.irq = 0;
      e = exp_q.pop_front(); a = ack_q.pop_front();
      total++; if (b.pc !== e || b.irq_ack !== a) $display("FAIL irq_seq step %0d got pc %h ack %b want pc %h ack %b", i, b.pc, b.irq_ack, e, a); else passed++;
    end
    total++; if (b.depth !== 4'd1 || b.in_isr !== 1'b1) $display("FAIL irq_depth got %0d/%b want 1/1", b.depth, b.in_isr); else passed++;
    repeat (3) tick();
    b.ins_op = RETI_OP_DEF; tick(); b.ins_op = 0;
    total++; if (b.pc !== 8'hF3 || b.flag_restore_valid !== 1'b0) $display("FAIL reti_restore_cycle got pc %h valid %b want F3 0", b.pc, b.flag_restore_valid); else passed++;
    tick(); f = ret_q.pop_back();
    total++; if (b.pc !== f[11:4] || b.flag_restore !== f[3:0] || b.flag_restore_valid !== 1'b1) $display("FAIL reti_return got pc %h flags %b valid %b want %h %b 1", b.pc, b.flag_restore, b.flag_restore_valid, f[11:4], f[3:0]); else passed++;
    total++; if (b.depth !== 4'd0) $display("FAIL reti_depth got %0d want 0", b.depth); else passed++;
    tick();
    total++; if (b.flag_restore_valid !== 1'b0 || b.pc !== f[11:4] + 8'd1) $display("FAIL reti_after got pc %h valid %b want %h 0", b.pc, b.flag_restore_valid, f[11:4] + 8'd1); else passed++;
  endtask
  task automatic test_irq_jump();
    logic [11:0] f;
    restart();
    b.irq = 1; tick(); b.irq = 0;
    b.jmp_req = 1; b.jmp_loc = 8'h40; b.flag_ex = 4'b0101; ret_q.push_back({8'h40, 4'b0101});
    tick(); b.jmp_req = 0;
    total++; if (b.pc !== 8'h40 || b.irq_ack !== 1'b1) $display("FAIL irqjmp_accept got pc %h ack %b want 40 1", b.pc, b.irq_ack); else passed++;
    tick(); tick();
    total++; if (b.pc !== 8'hF0) $display("FAIL irqjmp_vector got %h want F0", b.pc); else passed++;
    b.ins_op = RETI_OP_DEF; tick(); b.ins_op = 0; tick(); f = ret_q.pop_back();
    total++; if (b.pc !== f[11:4] || b.flag_restore !== f[3:0]) $display("FAIL irqjmp_return got %h/%b want %h/%b", b.pc, b.flag_restore, f[11:4], f[3:0]); else passed++;
  endtask
  task automatic test_masked();
    restart();
    b.irq_en = 0; b.irq = 1; tick(); b.irq = 0;
    repeat (3) begin
      tick();
      total++; if (b.irq_ack !== 1'b0) $display("FAIL masked_ack got %b want 0", b.irq_ack); else passed++;
    end
    b.irq_en = 1; tick();
    total++; if (b.irq_ack !== 1'b1) $display("FAIL masked_release got %b want 1", b.irq_ack); else passed++;
    tick(); tick();
    total++; if (b.pc !== 8'hF0) $display("FAIL masked_vector got %h want F0", b.pc); else passed++;
  endtask
  task automatic test_nesting();
    logic [11:0] f;
    restart();
    for (int i = 0; i < 4; i++) begin
      b.irq = 1; tick(); b.irq = 0;
      b.jmp_req = 1; b.jmp_loc = 8'h50 + 8'(i); b.flag_ex = 4'(i);
      ret_q.push_back({8'h50 + 8'(i), 4'(i)});
      tick(); b.jmp_req = 0;
      total++; if (b.irq_ack !== 1'b1) $display("FAIL nest_ack level %0d got %b want 1", i, b.irq_ack); else passed++;
      tick(); tick();
      total++; if (b.pc !== 8'hF0 || b.depth !== 4'(i + 1)) $display("FAIL nest_level %0d got pc %h depth %0d want F0 %0d", i, b.pc, b.depth, i + 1); else passed++;
    end
    b.irq = 1; tick(); b.irq = 0;
    b.jmp_req = 1; b.jmp_loc = 8'h60; tick(); b.jmp_req = 0;
    total++; if (b.irq_ack !== 1'b0 || b.pc !== 8'h60 || b.depth !== 4'd4) $display("FAIL nest_full got ack %b pc %h depth %0d want 0 60 4", b.irq_ack, b.pc, b.depth); else passed++;
    repeat (2) begin
      tick();
      total++; if (b.irq_ack !== 1'b0) $display("FAIL nest_full_hold got %b want 0", b.irq_ack); else passed++;
    end
    b.ins_op = RETI_OP_DEF; tick(); b.ins_op = 0; tick(); f = ret_q.pop_back();
    total++; if (b.pc !== f[11:4] || b.flag_restore !== f[3:0] || b.depth !== 4'd3) $display("FAIL nest_first_pop got %h/%b/%0d want %h/%b/3", b.pc, b.flag_restore, b.depth, f[11:4], f[3:0]); else passed++;
    b.flag_ex = 4'hA; ret_q.push_back({8'h54, 4'hA}); tick();
    total++; if (b.irq_ack !== 1'b1 || b.pc !== 8'h54) $display("FAIL nest_fifth_accept got ack %b pc %h want 1 54", b.irq_ack, b.pc); else passed++;
    tick(); tick();
    total++; if (b.pc !== 8'hF0 || b.depth !== 4'd4) $display("FAIL nest_fifth_vector got %h/%0d want F0/4", b.pc, b.depth); else passed++;
    for (int j = 0; j < 4; j++) begin
      b.ins_op = RETI_OP_DEF; tick(); b.ins_op = 0; tick(); f = ret_q.pop_back();
      total++; if (b.pc !== f[11:4] || b.flag_restore !== f[3:0] || b.depth !== 4'(ret_q.size())) $display("FAIL nest_pop %0d got %h/%b/%0d want %h/%b/%0d", j, b.pc, b.flag_restore, b.depth, f[11:4], f[3:0], ret_q.size()); else passed++;
    end
  endtask
  task automatic test_fault();
    restart();
    tick(); tick();
    b.ins_op = RETI_OP_DEF; tick();
    total++; if (b.fault !== 1'b1 || b.pc !== 8'h02) $display("FAIL fault_set got %b pc %h want 1 02", b.fault, b.pc); else passed++;
    b.ins_op = 0; b.jmp_req = 1; b.jmp_loc = 8'h77;
    repeat (3) begin
      tick();
      total++; if (b.fault !== 1'b1 || b.pc !== 8'h02) $display("FAIL fault_hold got %b pc %h want 1 02", b.fault, b.pc); else passed++;
    end
    b.jmp_req = 0; reset = 1; tick();
    total++; if (b.fault !== 1'b0 || b.pc !== 8'h00) $display("FAIL fault_reset got %b pc %h want 0 00", b.fault, b.pc); else passed++;
    reset = 0;
  endtask
  task automatic test_reset_save();
    restart();
    b.irq = 1; tick(); b.irq = 0; tick();
    total++; if (b.irq_ack !== 1'b1 || b.pc !== 8'h02) $display("FAIL rsave_enter got ack %b pc %h want 1 02", b.irq_ack, b.pc); else passed++;
    reset = 1; tick();
    total++; if (b.pc !== 8'h00 || b.depth !== 4'd0 || b.irq_ack !== 1'b0) $display("FAIL rsave_abort got pc %h depth %0d ack %b want 00 0 0", b.pc, b.depth, b.irq_ack); else passed++;
    reset = 0; tick(); tick();
    total++; if (b.pc !== 8'h02 || b.depth !== 4'd0 || b.irq_ack !== 1'b0) $display("FAIL rsave_after got pc %h depth %0d ack %b want 02 0 0", b.pc, b.depth, b.irq_ack); else passed++;
  endtask
  initial begin
    test_reset();
    test_freerun();
    test_jump();
    test_irq();
    test_irq_jump();
    test_masked();
    test_nesting();
    test_fault();
    test_reset_save();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
